// File: rtl/imem_responder_if.sv
// Fetch request/response handshake bundle for the instruction memory responder.
// The slave modport is the responder side; master is the fetch unit side.
interface imem_responder_if #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
);
    logic              i_req_valid;
    logic              o_req_ready;
    logic [ADDR_W-1:0] i_req_addr;
    logic              o_rsp_valid;
    logic              i_rsp_ready;
    logic [INST_W-1:0] o_rsp_inst;
    logic [ADDR_W-1:0] o_rsp_addr;
    logic              o_rsp_err;

    modport slave (
        input  i_req_valid,
        input  i_req_addr,
        input  i_rsp_ready,
        output o_req_ready,
        output o_rsp_valid,
        output o_rsp_inst,
        output o_rsp_addr,
        output o_rsp_err
    );

    modport master (
        output i_req_valid,
        output i_req_addr,
        output i_rsp_ready,
        input  o_req_ready,
        input  o_rsp_valid,
        input  o_rsp_inst,
        input  o_rsp_addr,
        input  o_rsp_err
    );
endinterface

// File: rtl/imem_responder.sv
// Instruction memory responder: a one-entry request stage feeds a 3-entry
// response FIFO, giving a fixed 2-cycle fetch latency and full throughput.
// Misaligned or out-of-range fetches answer with a NOP and the error flag.
module imem_responder #(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter int                DEPTH    = 256,
    parameter logic [INST_W-1:0] NOP_INST = INST_W'(32'h0000_0013)
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    imem_responder_if.slave          bus,
    input  logic                     i_flush,
    input  logic                     i_load_en,
    input  logic [$clog2(DEPTH)-1:0] i_load_idx,
    input  logic [INST_W-1:0]        i_load_data
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int LIM_W = ADDR_W + 1;
    // Byte address one past the last stored word; compared with one spare bit
    // so the limit is representable even when it equals 2**ADDR_W.
    localparam logic [LIM_W-1:0] LIMIT_BYTES = LIM_W'(DEPTH * 4);

    logic [INST_W-1:0] mem_r [DEPTH];

    logic              stage_valid_r;
    logic [ADDR_W-1:0] stage_addr_r;
    logic              stage_err_r;

    logic [INST_W-1:0] fifo_inst_r [3];
    logic [ADDR_W-1:0] fifo_addr_r [3];
    logic              fifo_err_r  [3];
    logic [1:0]        wr_ptr_r;
    logic [1:0]        rd_ptr_r;
    logic [1:0]        count_r;

    logic [1:0]        occ_s;
    logic              req_ready_s;
    logic              accept_s;
    logic              push_s;
    logic              pop_s;
    logic              req_err_s;
    logic [IDX_W-1:0]  rd_idx_s;
    logic [INST_W-1:0] rd_inst_s;

    // Advance a FIFO pointer around the three slots.
    function automatic logic [1:0] next_ptr(input logic [1:0] ptr);
        logic [1:0] nxt;
        case (ptr)
            2'd0:    nxt = 2'd1;
            2'd1:    nxt = 2'd2;
            2'd2:    nxt = 2'd0;
            default: nxt = 2'd0;
        endcase
        return nxt;
    endfunction

    // Handshake qualifiers, error classification and storage read for the stage.
    always_comb begin
        occ_s       = count_r + {1'b0, stage_valid_r};
        req_ready_s = !i_rst && !i_flush && (occ_s < 2'd3);
        accept_s    = bus.i_req_valid && req_ready_s;
        push_s      = stage_valid_r;
        pop_s       = (count_r != 2'd0) && bus.i_rsp_ready;
        req_err_s   = (bus.i_req_addr[1:0] != 2'b00) ||
                      ({1'b0, bus.i_req_addr} >= LIMIT_BYTES);
        rd_idx_s    = stage_addr_r[IDX_W+1:2];
        if (stage_err_r) begin
            rd_inst_s = NOP_INST;
        end else begin
            rd_inst_s = mem_r[rd_idx_s];
        end
    end

    // Backdoor storage writes; independent of reset so contents survive it.
    always_ff @(posedge i_clk) begin
        if (i_load_en) begin
            mem_r[i_load_idx] <= i_load_data;
        end
    end

    // Request stage and response FIFO; reset and flush both empty the pipeline.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            stage_valid_r <= 1'b0;
            wr_ptr_r      <= 2'd0;
            rd_ptr_r      <= 2'd0;
            count_r       <= 2'd0;
        end else begin
            stage_valid_r <= accept_s;
            if (accept_s) begin
                stage_addr_r <= bus.i_req_addr;
                stage_err_r  <= req_err_s;
            end
            if (push_s) begin
                fifo_inst_r[wr_ptr_r] <= rd_inst_s;
                fifo_addr_r[wr_ptr_r] <= stage_addr_r;
                fifo_err_r[wr_ptr_r]  <= stage_err_r;
                wr_ptr_r              <= next_ptr(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= next_ptr(rd_ptr_r);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    assign bus.o_req_ready = req_ready_s;
    assign bus.o_rsp_valid = (count_r != 2'd0);
    assign bus.o_rsp_inst  = fifo_inst_r[rd_ptr_r];
    assign bus.o_rsp_addr  = fifo_addr_r[rd_ptr_r];
    assign bus.o_rsp_err   = fifo_err_r[rd_ptr_r];
endmodule
